// File: rtl/llc_mem_bridge.sv
// LLC-to-memory bridge: converts one cache-line request from the LLC into
// a sequence of word beats on a narrow memory port. Writebacks are split into
// WORDS_PER_LINE write beats. Fills issue one read beat at a time, collect each
// read word into a line buffer, and hand the assembled line back to the LLC.
// All outputs are registered and are driven to zero while reset is asserted.
module llc_mem_bridge #(
    parameter int WORDS_PER_LINE = 4,
    parameter int BITS_PER_WORD  = 64,
    parameter int LINE_ADDR_BITS = 26,
    localparam int WOFF_BITS     = $clog2(WORDS_PER_LINE),
    localparam int LINE_BITS     = WORDS_PER_LINE * BITS_PER_WORD
) (
    input  logic                                clk,
    input  logic                                rst,
    // LLC request side
    input  logic                                llc_mem_req_valid,
    output logic                                llc_mem_req_ready,
    input  logic                                llc_mem_req_data_hwrite,
    input  logic [2:0]                          llc_mem_req_data_hsize,
    input  logic [1:0]                          llc_mem_req_data_hprot,
    input  logic [LINE_ADDR_BITS-1:0]           llc_mem_req_data_addr,
    input  logic [LINE_BITS-1:0]                llc_mem_req_data_line,
    // LLC fill response side
    output logic                                llc_mem_rsp_valid,
    input  logic                                llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0]                llc_mem_rsp_data_line,
    // Memory word-beat request side
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic                                mem_req_write,
    output logic [LINE_ADDR_BITS+WOFF_BITS-1:0] mem_req_addr,
    output logic [2:0]                          mem_req_hsize,
    output logic [1:0]                          mem_req_hprot,
    output logic [BITS_PER_WORD-1:0]            mem_req_wdata,
    // Memory read response side
    input  logic                                mem_rsp_valid,
    output logic                                mem_rsp_ready,
    input  logic [BITS_PER_WORD-1:0]            mem_rsp_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RSP  = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

    localparam logic [WOFF_BITS-1:0] LAST_IDX = WOFF_BITS'(WORDS_PER_LINE - 1);
    localparam logic [WOFF_BITS-1:0] IDX_ONE  = WOFF_BITS'(1);

    // Extract word idx from a line (word 0 occupies the least significant bits).
    function automatic logic [BITS_PER_WORD-1:0] word_sel(
        input logic [LINE_BITS-1:0] line,
        input logic [WOFF_BITS-1:0] idx
    );
        return line[int'(idx) * BITS_PER_WORD +: BITS_PER_WORD];
    endfunction

    // Transaction state
    state_t                      state_r,  state_nxt_s;
    logic [WOFF_BITS-1:0]        idx_r,    idx_nxt_s;
    logic                        write_r,  write_nxt_s;
    logic [2:0]                  hsize_r,  hsize_nxt_s;
    logic [1:0]                  hprot_r,  hprot_nxt_s;
    logic [LINE_ADDR_BITS-1:0]   addr_r,   addr_nxt_s;
    logic [LINE_BITS-1:0]        line_r,   line_nxt_s;

    // Registered outputs and their next values
    logic                                llc_req_ready_r,  llc_req_ready_nxt_s;
    logic                                llc_rsp_valid_r,  llc_rsp_valid_nxt_s;
    logic [LINE_BITS-1:0]                llc_rsp_line_r,   llc_rsp_line_nxt_s;
    logic                                mreq_valid_r,     mreq_valid_nxt_s;
    logic                                mreq_write_r,     mreq_write_nxt_s;
    logic [LINE_ADDR_BITS+WOFF_BITS-1:0] mreq_addr_r,      mreq_addr_nxt_s;
    logic [2:0]                          mreq_hsize_r,     mreq_hsize_nxt_s;
    logic [1:0]                          mreq_hprot_r,     mreq_hprot_nxt_s;
    logic [BITS_PER_WORD-1:0]            mreq_wdata_r,     mreq_wdata_nxt_s;
    logic                                mrsp_ready_r,     mrsp_ready_nxt_s;

    // Handshakes are qualified with the registered ready/valid the partner sees
    logic req_acc_s;
    logic beat_hs_s;
    logic rsp_hs_s;
    logic fill_hs_s;
    logic last_s;

    assign req_acc_s = llc_mem_req_valid & llc_req_ready_r;
    assign beat_hs_s = mreq_valid_r & mem_req_ready;
    assign rsp_hs_s  = mrsp_ready_r & mem_rsp_valid;
    assign fill_hs_s = llc_rsp_valid_r & llc_mem_rsp_ready;
    assign last_s    = (idx_r == LAST_IDX);

    // Next-state, word index and capture/assembly datapath
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        write_nxt_s = write_r;
        hsize_nxt_s = hsize_r;
        hprot_nxt_s = hprot_r;
        addr_nxt_s  = addr_r;
        line_nxt_s  = line_r;
        case (state_r)
            IDLE: begin
                if (req_acc_s) begin
                    write_nxt_s = llc_mem_req_data_hwrite;
                    hsize_nxt_s = llc_mem_req_data_hsize;
                    hprot_nxt_s = llc_mem_req_data_hprot;
                    addr_nxt_s  = llc_mem_req_data_addr;
                    line_nxt_s  = llc_mem_req_data_line;
                    idx_nxt_s   = '0;
                    state_nxt_s = llc_mem_req_data_hwrite ? WR_REQ : RD_REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_REQ: begin
                if (beat_hs_s) begin
                    if (last_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        idx_nxt_s = idx_r + IDX_ONE;
                    end
                end else begin
                    state_nxt_s = WR_REQ;
                end
            end
            RD_REQ: begin
                if (beat_hs_s) begin
                    state_nxt_s = RD_WAIT;
                end else begin
                    state_nxt_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (rsp_hs_s) begin
                    line_nxt_s[int'(idx_r) * BITS_PER_WORD +: BITS_PER_WORD] = mem_rsp_rdata;
                    if (last_s) begin
                        state_nxt_s = RD_RSP;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                        state_nxt_s = RD_REQ;
                    end
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            RD_RSP: begin
                if (fill_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Decode next-cycle output values from the next state and datapath
    always_comb begin
        llc_req_ready_nxt_s = (state_nxt_s == IDLE);
        llc_rsp_valid_nxt_s = (state_nxt_s == RD_RSP);
        mreq_valid_nxt_s    = (state_nxt_s == RD_REQ) || (state_nxt_s == WR_REQ);
        mreq_write_nxt_s    = (state_nxt_s == WR_REQ);
        mrsp_ready_nxt_s    = (state_nxt_s == RD_WAIT);
        if (mreq_valid_nxt_s) begin
            mreq_addr_nxt_s = {addr_nxt_s, idx_nxt_s};
        end else begin
            mreq_addr_nxt_s = '0;
        end
        if (mreq_write_nxt_s) begin
            mreq_wdata_nxt_s = word_sel(line_nxt_s, idx_nxt_s);
        end else begin
            mreq_wdata_nxt_s = '0;
        end
        if (state_nxt_s != IDLE) begin
            mreq_hsize_nxt_s = hsize_nxt_s;
            mreq_hprot_nxt_s = hprot_nxt_s;
        end else begin
            mreq_hsize_nxt_s = 3'b000;
            mreq_hprot_nxt_s = 2'b00;
        end
        if (llc_rsp_valid_nxt_s) begin
            llc_rsp_line_nxt_s = line_nxt_s;
        end else begin
            llc_rsp_line_nxt_s = '0;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            write_r <= 1'b0;
            hsize_r <= 3'b000;
            hprot_r <= 2'b00;
            addr_r  <= '0;
            line_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            write_r <= write_nxt_s;
            hsize_r <= hsize_nxt_s;
            hprot_r <= hprot_nxt_s;
            addr_r  <= addr_nxt_s;
            line_r  <= line_nxt_s;
        end
    end

    // Output registers; all zero in reset so ready only rises after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llc_req_ready_r <= 1'b0;
            llc_rsp_valid_r <= 1'b0;
            llc_rsp_line_r  <= '0;
            mreq_valid_r    <= 1'b0;
            mreq_write_r    <= 1'b0;
            mreq_addr_r     <= '0;
            mreq_hsize_r    <= 3'b000;
            mreq_hprot_r    <= 2'b00;
            mreq_wdata_r    <= '0;
            mrsp_ready_r    <= 1'b0;
        end else begin
            llc_req_ready_r <= llc_req_ready_nxt_s;
            llc_rsp_valid_r <= llc_rsp_valid_nxt_s;
            llc_rsp_line_r  <= llc_rsp_line_nxt_s;
            mreq_valid_r    <= mreq_valid_nxt_s;
            mreq_write_r    <= mreq_write_nxt_s;
            mreq_addr_r     <= mreq_addr_nxt_s;
            mreq_hsize_r    <= mreq_hsize_nxt_s;
            mreq_hprot_r    <= mreq_hprot_nxt_s;
            mreq_wdata_r    <= mreq_wdata_nxt_s;
            mrsp_ready_r    <= mrsp_ready_nxt_s;
        end
    end

    assign llc_mem_req_ready     = llc_req_ready_r;
    assign llc_mem_rsp_valid     = llc_rsp_valid_r;
    assign llc_mem_rsp_data_line = llc_rsp_line_r;
    assign mem_req_valid         = mreq_valid_r;
    assign mem_req_write         = mreq_write_r;
    assign mem_req_addr          = mreq_addr_r;
    assign mem_req_hsize         = mreq_hsize_r;
    assign mem_req_hprot         = mreq_hprot_r;
    assign mem_req_wdata         = mreq_wdata_r;
    assign mem_rsp_ready         = mrsp_ready_r;

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Scoreboard bench for llc_mem_bridge (default parameters: 4 words x 64 bits).
// Stimulus pushes the expected beats/lines derived from each request; a
// separate monitor pops and compares whenever the DUT presents output.
module tb_llc_mem_bridge;

    localparam int W    = 4;
    localparam int BPW  = 64;
    localparam int LAB  = 26;
    localparam int MAW  = LAB + 2;
    localparam int LB   = W * BPW;

    logic           clk;
    logic           rst;
    logic           llc_mem_req_valid;
    logic           llc_mem_req_ready;
    logic           llc_mem_req_data_hwrite;
    logic [2:0]     llc_mem_req_data_hsize;
    logic [1:0]     llc_mem_req_data_hprot;
    logic [LAB-1:0] llc_mem_req_data_addr;
    logic [LB-1:0]  llc_mem_req_data_line;
    logic           llc_mem_rsp_valid;
    logic           llc_mem_rsp_ready;
    logic [LB-1:0]  llc_mem_rsp_data_line;
    logic           mem_req_valid;
    logic           mem_req_ready;
    logic           mem_req_write;
    logic [MAW-1:0] mem_req_addr;
    logic [2:0]     mem_req_hsize;
    logic [1:0]     mem_req_hprot;
    logic [BPW-1:0] mem_req_wdata;
    logic           mem_rsp_valid;
    logic           mem_rsp_ready;
    logic [BPW-1:0] mem_rsp_rdata;

    llc_mem_bridge dut (
        .clk                     (clk),
        .rst                     (rst),
        .llc_mem_req_valid       (llc_mem_req_valid),
        .llc_mem_req_ready       (llc_mem_req_ready),
        .llc_mem_req_data_hwrite (llc_mem_req_data_hwrite),
        .llc_mem_req_data_hsize  (llc_mem_req_data_hsize),
        .llc_mem_req_data_hprot  (llc_mem_req_data_hprot),
        .llc_mem_req_data_addr   (llc_mem_req_data_addr),
        .llc_mem_req_data_line   (llc_mem_req_data_line),
        .llc_mem_rsp_valid       (llc_mem_rsp_valid),
        .llc_mem_rsp_ready       (llc_mem_rsp_ready),
        .llc_mem_rsp_data_line   (llc_mem_rsp_data_line),
        .mem_req_valid           (mem_req_valid),
        .mem_req_ready           (mem_req_ready),
        .mem_req_write           (mem_req_write),
        .mem_req_addr            (mem_req_addr),
        .mem_req_hsize           (mem_req_hsize),
        .mem_req_hprot           (mem_req_hprot),
        .mem_req_wdata           (mem_req_wdata),
        .mem_rsp_valid           (mem_rsp_valid),
        .mem_rsp_ready           (mem_rsp_ready),
        .mem_rsp_rdata           (mem_rsp_rdata)
    );

    typedef struct {
        logic           write;
        logic [MAW-1:0] addr;
        logic [BPW-1:0] wdata;
        logic [2:0]     hsize;
        logic [1:0]     hprot;
    } beat_t;

    beat_t         exp_beats[$];
    logic [LB-1:0] exp_lines[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rsp_hs_count = 0;

    // Environment knobs written by the stimulus only
    int             mr_mode = 0;
    int             lr_mode = 0;
    int             stall_beat = 0;
    int             stall_cfg = 0;
    int             lr_cfg = 0;
    int             rsp_max_delay = 0;
    bit             spur_en = 0;
    bit             zero_wait = 1;
    int             cfg_gen = 0;
    logic [BPW-1:0] rd_salt = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory and LLC-side agent: drives ready/response inputs at posedge+1
    initial begin : agent
        bit             hs_rd;
        bit             hs_rsp;
        logic [MAW-1:0] hs_addr;
        bit             real_valid;
        logic [BPW-1:0] real_data;
        bit             pend;
        int             pend_delay;
        logic [BPW-1:0] pend_data;
        int             seen_gen;
        int             stall_left;
        int             lr_left;
        real_valid = 0; real_data = '0; pend = 0; pend_delay = 0; pend_data = '0;
        seen_gen = -1; stall_left = 0; lr_left = 0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; llc_mem_rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            hs_rd   = rst && mem_req_valid && mem_req_ready && !mem_req_write;
            hs_addr = mem_req_addr;
            hs_rsp  = rst && mem_rsp_valid && mem_rsp_ready;
            @(posedge clk);
            #1;
            if (seen_gen != cfg_gen) begin
                seen_gen = cfg_gen; stall_left = stall_cfg; lr_left = lr_cfg;
            end
            if (!rst) begin
                real_valid = 0; pend = 0;
            end else begin
                if (hs_rsp) real_valid = 0;
                if (hs_rd) begin
                    pend = 1;
                    pend_delay = (rsp_max_delay == 0) ? 0 : int'($urandom_range(rsp_max_delay, 0));
                    pend_data = rd_salt + BPW'(hs_addr[1:0]);
                end
                if (pend && !real_valid) begin
                    if (pend_delay == 0) begin
                        real_valid = 1; real_data = pend_data; pend = 0;
                    end else begin
                        pend_delay--;
                    end
                end
            end
            if (real_valid) begin
                mem_rsp_valid = 1'b1; mem_rsp_rdata = real_data;
            end else if (spur_en && !mem_rsp_ready) begin
                mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD;
            end else begin
                mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
            end
            case (mr_mode)
                0: mem_req_ready = 1'b1;
                1: mem_req_ready = ($urandom_range(3, 0) != 0);
                default: begin
                    if (mem_req_valid && int'(mem_req_addr[1:0]) == stall_beat && stall_left > 0) begin
                        mem_req_ready = 1'b0; stall_left--;
                    end else begin
                        mem_req_ready = 1'b1;
                    end
                end
            endcase
            case (lr_mode)
                0: llc_mem_rsp_ready = 1'b1;
                1: llc_mem_rsp_ready = ($urandom_range(2, 0) != 0);
                default: begin
                    if (llc_mem_rsp_valid && lr_left > 0) begin
                        llc_mem_rsp_ready = 1'b0; lr_left--;
                    end else begin
                        llc_mem_rsp_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor / scoreboard: samples on the falling edge
    initial begin : monitor
        beat_t       e;
        logic [97:0] prev_mb;
        logic [LB-1:0] prev_line;
        bit          prev_mstall, prev_lstall, prev_lvalid;
        int          outstanding, rst_age, acc_cyc;
        bit          pend_wr, pend_rd, lat_zw;
        prev_mb = '0; prev_line = '0; prev_mstall = 0; prev_lstall = 0; prev_lvalid = 0;
        outstanding = 0; rst_age = 0; acc_cyc = 0; pend_wr = 0; pend_rd = 0; lat_zw = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs", {llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line,
                    mem_req_valid, mem_req_write, mem_req_addr, mem_req_hsize, mem_req_hprot,
                    mem_req_wdata, mem_rsp_ready}, '0);
                exp_beats.delete(); exp_lines.delete();
                prev_mstall = 0; prev_lstall = 0; prev_lvalid = 0;
                outstanding = 0; rst_age = 0; pend_wr = 0; pend_rd = 0;
            end else begin
                if (rst_age == 0) chk("ready_first_cycle_low", llc_mem_req_ready, 1'b0);
                else if (rst_age == 1) chk("ready_rises_after_reset", llc_mem_req_ready, 1'b1);
                if (rst_age < 2) rst_age++;
                chk("mem_rsp_ready", mem_rsp_ready, (outstanding == 1));
                if (llc_mem_req_ready) begin
                    chk("idle_outputs", {mem_req_valid, mem_req_hsize, mem_req_hprot, llc_mem_rsp_valid}, '0);
                    if (pend_wr) begin
                        if (lat_zw) chk("write_occupancy", cyc - acc_cyc, W);
                        pend_wr = 0;
                    end
                end
                // memory request beats
                if (mem_req_valid) begin
                    if (prev_mstall)
                        chk("mem_req_stable", {mem_req_write, mem_req_addr, mem_req_wdata, mem_req_hsize, mem_req_hprot}, prev_mb);
                    if (mem_req_ready) begin
                        if (exp_beats.size() == 0) begin
                            chk("unexpected_beat", {mem_req_write, mem_req_addr}, '1);
                        end else begin
                            e = exp_beats.pop_front();
                            chk("beat", {mem_req_write, mem_req_addr, mem_req_wdata, mem_req_hsize, mem_req_hprot},
                                {e.write, e.addr, e.wdata, e.hsize, e.hprot});
                        end
                    end
                end else if (prev_mstall) begin
                    chk("mem_req_valid_dropped", mem_req_valid, 1'b1);
                end
                // read responses consumed by the DUT
                if (mem_rsp_valid && mem_rsp_ready) begin
                    outstanding--;
                    rsp_hs_count++;
                end
                if (mem_req_valid && mem_req_ready && !mem_req_write) outstanding++;
                prev_mstall = mem_req_valid && !mem_req_ready;
                prev_mb = {mem_req_write, mem_req_addr, mem_req_wdata, mem_req_hsize, mem_req_hprot};
                // fill line to the LLC
                if (llc_mem_rsp_valid) begin
                    if (!prev_lvalid && pend_rd) begin
                        if (lat_zw) chk("read_latency", cyc - acc_cyc, 2 * W);
                        pend_rd = 0;
                    end
                    if (prev_lstall) chk("llc_line_stable", llc_mem_rsp_data_line, prev_line);
                    if (llc_mem_rsp_ready) begin
                        if (exp_lines.size() == 0) begin
                            chk("unexpected_llc_rsp", llc_mem_rsp_valid, 1'b0);
                        end else begin
                            chk("fill_line", llc_mem_rsp_data_line, exp_lines.pop_front());
                        end
                    end
                end else if (prev_lstall) begin
                    chk("llc_rsp_valid_dropped", llc_mem_rsp_valid, 1'b1);
                end
                prev_lstall = llc_mem_rsp_valid && !llc_mem_rsp_ready;
                prev_lvalid = llc_mem_rsp_valid;
                prev_line = llc_mem_rsp_data_line;
                // acceptance of a new LLC request
                if (llc_mem_req_valid && llc_mem_req_ready) begin
                    acc_cyc = cyc + 1;
                    lat_zw = zero_wait;
                    pend_wr = llc_mem_req_data_hwrite;
                    pend_rd = !llc_mem_req_data_hwrite;
                end
            end
        end
    end

    task automatic set_cfg(input int mrm, input int lrm, input int sb, input int sc,
                           input int lc, input int dly, input bit sp);
        mr_mode = mrm; lr_mode = lrm; stall_beat = sb; stall_cfg = sc; lr_cfg = lc;
        rsp_max_delay = dly; spur_en = sp; zero_wait = (mrm == 0 && dly == 0);
        cfg_gen++;
    endtask

    task automatic issue(input logic wr, input logic [LAB-1:0] a, input logic [LB-1:0] ln,
                         input logic [2:0] hs, input logic [1:0] hp);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        llc_mem_req_valid = 1'b1; llc_mem_req_data_hwrite = wr; llc_mem_req_data_addr = a;
        llc_mem_req_data_line = ln; llc_mem_req_data_hsize = hs; llc_mem_req_data_hprot = hp;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (llc_mem_req_ready) begin ok = 1; break; end
        end
        chk("req_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        llc_mem_req_valid = 1'b0;
        llc_mem_req_data_hwrite = 1'($urandom);
        llc_mem_req_data_addr = LAB'($urandom);
        llc_mem_req_data_line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_fill(input logic [LAB-1:0] a, input logic [2:0] hs, input logic [1:0] hp);
        logic [LB-1:0] ln;
        beat_t b;
        for (int i = 0; i < W; i++) begin
            b.write = 1'b0; b.addr = {a, 2'(i)}; b.wdata = '0; b.hsize = hs; b.hprot = hp;
            exp_beats.push_back(b);
            ln[i*BPW +: BPW] = rd_salt + BPW'(i);
        end
        exp_lines.push_back(ln);
        issue(1'b0, a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, hs, hp);
    endtask

    task automatic do_write(input logic [LAB-1:0] a, input logic [LB-1:0] ln,
                            input logic [2:0] hs, input logic [1:0] hp);
        beat_t b;
        for (int i = 0; i < W; i++) begin
            b.write = 1'b1; b.addr = {a, 2'(i)}; b.wdata = ln[i*BPW +: BPW]; b.hsize = hs; b.hprot = hp;
            exp_beats.push_back(b);
        end
        issue(1'b1, a, ln, hs, hp);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (exp_beats.size() == 0 && exp_lines.size() == 0 && llc_mem_req_ready) begin
                ok = 1; break;
            end
        end
        chk("txn_done_timeout", ok, 1'b1);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int base;
        bit ok;
        llc_mem_req_valid = 1'b0; llc_mem_req_data_hwrite = 1'b0; llc_mem_req_data_hsize = 3'd0;
        llc_mem_req_data_hprot = 2'd0; llc_mem_req_data_addr = '0; llc_mem_req_data_line = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // zero-wait fill with known data
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        rd_salt = 64'hA0;
        do_fill(26'h0000010, 3'd0, 2'd0);
        wait_done();

        // writeback with ready held high
        do_write(26'h0000020, {64'd4, 64'd3, 64'd2, 64'd1}, 3'd0, 2'd0);
        wait_done();

        // size/protection forwarding on a fill
        rd_salt = {$urandom, $urandom};
        do_fill(LAB'($urandom), 3'd3, 2'b01);
        wait_done();

        // backpressure: beat 2 stalled 3 cycles, LLC ready low 5 cycles
        set_cfg(2, 2, 2, 3, 5, 0, 0);
        rd_salt = {$urandom, $urandom};
        do_fill(LAB'($urandom), 3'd2, 2'b10);
        wait_done();

        // spurious memory responses outside RD_WAIT
        set_cfg(0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        rd_salt = {$urandom, $urandom};
        do_fill(LAB'($urandom), 3'd1, 2'b11);
        wait_done();

        // reset in the middle of a fill, then a fresh fill
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        rd_salt = 64'h5500;
        base = rsp_hs_count;
        do_fill(26'h0000123, 3'd0, 2'd0);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_hs_count >= base + 2) begin ok = 1; break; end
        end
        chk("midfill_progress_timeout", ok, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        rd_salt = 64'h7700;
        do_fill(26'h0000456, 3'd0, 2'd0);
        wait_done();

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            set_cfg(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), 0, 0, 0,
                    int'($urandom_range(3, 0)), bit'($urandom_range(1, 0)));
            rd_salt = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1)
                do_write(LAB'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                         3'($urandom), 2'($urandom));
            else
                do_fill(LAB'($urandom), 3'($urandom), 2'($urandom));
            wait_done();
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
